regfile_multiport: RTL and testbench

Parametrised successor to the core register file. It provides NUM_RD registered read ports, one write port, write-to-read bypass, an optional hardwired zero register and range checking. An initialisation sequencer fills the array one entry per cycle, after reset or on request, and reports completion on `ready`. It sits between decode (read addresses) and writeback (write port) in the datapath.

---
 rtl/regfile_multiport_pkg.sv | 20 ++
 rtl/regfile_multiport_if.sv | 32 +++
 rtl/regfile_multiport_rd_port.sv | 50 +++++
 rtl/regfile_multiport.sv | 120 ++++++++++++
 tb/tb_regfile_multiport.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/regfile_multiport_pkg.sv
// Shared types, default sizes and the initialisation-value helper for the
// multi-port register file.
package regfile_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} rf_state_e;

  localparam int RF_DATA_W   = 64;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_RD   = 2;
  localparam int CNT_W       = $clog2(RF_NUM_REGS);
  localparam int INIT_W      = 64;

  // mode 0 clears the entry, mode 1 loads the entry's own index
  function automatic logic [INIT_W-1:0] init_value(input logic [31:0] idx,
                                                   input logic        mode);
    return mode ? INIT_W'(idx) : '0;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Decode/writeback-facing bus of the register file.
// Handshake: rd_en and we are single-cycle strobes taken on any rising edge
// while ready is high (no back-pressure); rd_valid pulses the cycle after a
// taken read and qualifies rd_data; strobes seen while ready is low are
// dropped and flagged on busy_err.
interface regfile_multiport_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     init_req;
  logic                     rd_en;
  logic [NUM_RD*ADDR_W-1:0] rs_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     ready;
  logic                     addr_err;
  logic                     busy_err;

  modport master (
    output init_req, rd_en, rs_addr, we, wr_addr, wr_data,
    input  rd_data, rd_valid, ready, addr_err, busy_err
  );

  modport slave (
    input  init_req, rd_en, rs_addr, we, wr_addr, wr_data,
    output rd_data, rd_valid, ready, addr_err, busy_err
  );
endinterface

// File: rtl/regfile_multiport_rd_port.sv
// One registered read port: range check, hardwired-zero and write bypass
// selection in front of the output register.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_mem,
  input  logic              i_wr_hit,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_oor,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] w_next;
  logic [DATA_W-1:0] r_data;

  assign o_oor = ({1'b0, i_addr} >= LIMIT);

  // i_wr_hit already excludes out-of-range and zero-register writes
  always_comb begin
    w_next = i_mem;
    if (o_oor)
      w_next = '0;
    else if (ZERO_REG != 0 && i_addr == '0)
      w_next = '0;
    else if (i_wr_hit && i_wr_addr == i_addr)
      w_next = i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n)
      r_data <= '0;
    else if (i_rd)
      r_data <= w_next;
  end

  assign o_data = r_data;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_RD registered read ports, one write port and
// an INIT sequencer that rewrites every entry after reset or on init_req.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W    = RF_DATA_W,
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int NUM_RD    = RF_NUM_RD,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic               clk,
  input  logic               reset,
  regfile_multiport_if.slave rf,
  output rf_state_e          o_state
);

  localparam int                   LCL_CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W:0]      LIMIT     = (ADDR_W+1)'(NUM_REGS);
  localparam logic [LCL_CNT_W-1:0] LAST      = LCL_CNT_W'(NUM_REGS - 1);

  logic [DATA_W-1:0]    r_mem [NUM_REGS];
  rf_state_e            r_state;
  logic [LCL_CNT_W-1:0] r_init_cnt;
  logic                 r_ready;
  logic                 r_rd_valid;
  logic                 r_addr_err;
  logic                 r_busy_err;

  logic                 w_run;
  logic                 w_wr_oor;
  logic                 w_wr_hit;
  logic                 w_rd_go;
  logic [NUM_RD-1:0]    w_rd_oor;
  logic [DATA_W-1:0]    w_init_val;

  assign w_run      = (r_state == RUN);
  assign w_wr_oor   = ({1'b0, rf.wr_addr} >= LIMIT);
  assign w_wr_hit   = reset && w_run && rf.we && !w_wr_oor &&
                      !(ZERO_REG != 0 && rf.wr_addr == '0);
  assign w_rd_go    = w_run && rf.rd_en;
  assign w_init_val = DATA_W'(init_value(32'(r_init_cnt), INIT_MODE != 0));

  // Array has no reset of its own; INIT rewrites every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      if (!w_run)
        r_mem[r_init_cnt] <= w_init_val;
      else if (w_wr_hit)
        r_mem[rf.wr_addr] <= rf.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_addr_err <= 1'b0;
      r_busy_err <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_go;
      r_addr_err <= w_run && ((rf.we && w_wr_oor) || (rf.rd_en && |w_rd_oor));
      r_busy_err <= !w_run && (rf.rd_en || rf.we);
      case (r_state)
        INIT: begin
          if (r_init_cnt == LAST) begin
            r_state    <= RUN;
            r_ready    <= 1'b1;
            r_init_cnt <= '0;
          end else begin
            r_init_cnt <= r_init_cnt + 1'b1;
          end
        end
        RUN: begin
          if (rf.init_req) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_mem;
    assign w_addr = rf.rs_addr[k*ADDR_W +: ADDR_W];
    assign w_mem  = r_mem[w_addr];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .clk       (clk),
      .i_rst_n   (reset),
      .i_rd      (w_rd_go),
      .i_addr    (w_addr),
      .i_mem     (w_mem),
      .i_wr_hit  (w_wr_hit),
      .i_wr_addr (rf.wr_addr),
      .i_wr_data (rf.wr_data),
      .o_oor     (w_rd_oor[k]),
      .o_data    (rf.rd_data[k*DATA_W +: DATA_W])
    );
  end

  assign rf.ready    = r_ready;
  assign rf.rd_valid = r_rd_valid;
  assign rf.addr_err = r_addr_err;
  assign rf.busy_err = r_busy_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: a default 32-entry instance and an 18-entry instance for
// range checks, sharing clock and reset.
module tb_regfile_multiport;
  import regfile_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) a_if ();
  regfile_multiport_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) b_if ();
  rf_state_e a_state;
  rf_state_e b_state;

  regfile_multiport dut_a (
    .clk     (clk),
    .reset   (reset),
    .rf      (a_if.slave),
    .o_state (a_state)
  );

  regfile_multiport #(.NUM_REGS(18)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .rf      (b_if.slave),
    .o_state (b_state)
  );

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input bit b, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic rd,
                       input logic [4:0] a0, input logic [4:0] a1, input logic ireq);
    if (b) begin
      b_if.we = we; b_if.wr_addr = wa; b_if.wr_data = wd;
      b_if.rd_en = rd; b_if.rs_addr = {a1, a0}; b_if.init_req = ireq;
    end else begin
      a_if.we = we; a_if.wr_addr = wa; a_if.wr_data = wd;
      a_if.rd_en = rd; a_if.rs_addr = {a1, a0}; a_if.init_req = ireq;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  // one read (optionally with a write on the same edge), checked through exp_q
  task automatic access(input bit b, input string tag, input logic we,
                        input logic [4:0] wa, input logic [63:0] wd,
                        input logic [4:0] a0, input logic [4:0] a1,
                        input logic [63:0] e0, input logic [63:0] e1,
                        input logic exp_err);
    logic [127:0] got;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    drive(b, we, wa, wd, 1'b1, a0, a1, 1'b0);
    tick();
    idle();
    got = b ? b_if.rd_data : a_if.rd_data;
    chk({tag, " rd_valid"}, 64'(b ? b_if.rd_valid : a_if.rd_valid), 64'd1);
    chk({tag, " addr_err"}, 64'(b ? b_if.addr_err : a_if.addr_err), 64'(exp_err));
    chk({tag, " p0"}, got[63:0], exp_q.pop_front());
    chk({tag, " p1"}, got[127:64], exp_q.pop_front());
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (a_if.ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " edges to ready"}, 64'(n), 64'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle();
    tick();
    tick();
    chk("reset ready", 64'(a_if.ready), 64'd0);
    chk("reset rd_valid", 64'(a_if.rd_valid), 64'd0);
    chk("reset rd_data", a_if.rd_data[63:0], 64'd0);
    chk("reset state", 64'(a_state), 64'(INIT));

    reset = 1'b1;
    wait_ready("boot", 32);
    chk("b ready", 64'(b_if.ready), 64'd1);

    access(1'b0, "init r5 r17", 1'b0, 5'd0, 64'd0, 5'd5, 5'd17, 64'd5, 64'd17, 1'b0);
    tick();
    chk("hold rd_valid", 64'(a_if.rd_valid), 64'd0);
    chk("hold rd_data", a_if.rd_data[63:0], 64'd5);

    access(1'b0, "bypass r9", 1'b1, 5'd9, 64'hDEAD_BEEF, 5'd9, 5'd0, 64'hDEAD_BEEF, 64'd0, 1'b0);
    access(1'b0, "reread r9", 1'b0, 5'd0, 64'd0, 5'd9, 5'd9, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0);

    drive(1'b0, 1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    idle();
    chk("zero wr addr_err", 64'(a_if.addr_err), 64'd0);
    access(1'b0, "zero read", 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 64'd0, 64'd0, 1'b0);

    // range checks on the 18-entry instance
    drive(1'b1, 1'b1, 5'd20, 64'hFFFF, 1'b0, 5'd0, 5'd0, 1'b0);
    tick();
    idle();
    chk("b wr20 addr_err", 64'(b_if.addr_err), 64'd1);
    tick();
    chk("b addr_err pulse", 64'(b_if.addr_err), 64'd0);
    access(1'b1, "b r4 r17", 1'b0, 5'd0, 64'd0, 5'd4, 5'd17, 64'd4, 64'd17, 1'b0);
    access(1'b1, "b r25", 1'b0, 5'd0, 64'd0, 5'd25, 5'd2, 64'd0, 64'd2, 1'b1);
    access(1'b1, "b wr17 r18", 1'b1, 5'd17, 64'hAB, 5'd17, 5'd18, 64'hAB, 64'd0, 1'b1);
    access(1'b1, "b oor both", 1'b1, 5'd30, 64'h1234, 5'd25, 5'd1, 64'd0, 64'd1, 1'b1);
    tick();
    chk("b single pulse", 64'(b_if.addr_err), 64'd0);
    access(1'b1, "b r17 r16", 1'b0, 5'd0, 64'd0, 5'd17, 5'd16, 64'hAB, 64'd16, 1'b0);

    // re-initialisation on request
    access(1'b0, "wr r3", 1'b1, 5'd3, 64'h77, 5'd3, 5'd31, 64'h77, 64'd31, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();
    idle();
    chk("init_req ready", 64'(a_if.ready), 64'd0);
    chk("init_req state", 64'(a_state), 64'(INIT));
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3, 1'b0);
    tick();
    idle();
    chk("busy_err", 64'(a_if.busy_err), 64'd1);
    chk("busy rd_valid", 64'(a_if.rd_valid), 64'd0);
    chk("busy rd_data hold", a_if.rd_data[63:0], 64'h77);
    wait_ready("reinit", 31);
    access(1'b0, "after reinit", 1'b0, 5'd0, 64'd0, 5'd3, 5'd9, 64'd3, 64'd9, 1'b0);

    // reset in the middle of INIT
    drive(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 10; i++) tick();
    chk("mid init state", 64'(a_state), 64'(INIT));
    reset = 1'b0;
    tick();
    chk("mid rst rd_data", a_if.rd_data, 64'd0);
    chk("mid rst ready", 64'(a_if.ready), 64'd0);
    reset = 1'b1;
    wait_ready("restart", 32);
    access(1'b0, "after restart", 1'b0, 5'd0, 64'd0, 5'd31, 5'd10, 64'd31, 64'd10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
